// File: rtl/adc_bcd_sequencer.sv
// -----------------------------------------------------------------------------
// adc_bcd_sequencer
//
// Converts raw 12-bit unipolar XADC codes for 13 channels into 4-digit packed
// BCD millivolt words and holds one word per channel for the character
// renderer. A single multiplier plus a sequential 14-iteration double-dabble
// converter is shared by all channels. Samples enter via a ready/valid
// handshake and each conversion occupies 17 cycles.
//
// Optional feature macro: ADC_BCD_FRAME_SYNC_EN
//   When defined, conversions land in per-channel shadow registers. All
//   shadows are copied to out0..out12 together on frame_tick, so the display
//   never shows a half-updated frame. When undefined, outputs update directly
//   at the end of each conversion and frame_tick is ignored.
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   sample        raw 12-bit XADC code
//   sample_ch     channel index (0..12 stored; 13..15 discarded)
//   sample_valid  sample/sample_ch valid
//   sample_ready  high only while idle; accept on valid && ready
//   frame_tick    one-cycle frame pulse (used only with ADC_BCD_FRAME_SYNC_EN)
//   out0..out12   packed BCD millivolts, most significant digit in [15:12]
//   updated       one-cycle pulse when the output words are written
//
// Parameters
//   SCALE  millivolts at full-scale code 4096 (1..16383)
//   NCH    number of channels held (fixed at 13)
// -----------------------------------------------------------------------------
module adc_bcd_sequencer #(
  parameter int unsigned SCALE = 3300,
  parameter int unsigned NCH   = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample,
  input  logic [3:0]  sample_ch,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        frame_tick,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic [15:0] out3,
  output logic [15:0] out4,
  output logic [15:0] out5,
  output logic [15:0] out6,
  output logic [15:0] out7,
  output logic [15:0] out8,
  output logic [15:0] out9,
  output logic [15:0] out10,
  output logic [15:0] out11,
  output logic [15:0] out12,
  output logic        updated
);

  localparam int DATA_W = 12;              // ADC code width
  localparam int COEF_W = 14;              // scale factor / millivolt width
  localparam int STAGES = 14;              // double-dabble iterations
  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic [COEF_W-1:0] SCALE_C = COEF_W'(SCALE);
  localparam logic [COEF_W-1:0] MV_MAX  = 14'd9999;
  localparam logic [3:0]        NCH_C   = 4'(NCH);
  localparam logic [3:0]        LAST_IT = 4'(STAGES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    SHIFT = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   code_p0;   // latched sample code
  logic [3:0]          ch_p0;     // latched channel index
  logic [COEF_W-1:0]   mv_p1;     // scaled millivolts, consumed MSB-first
  logic [15:0]         bcd_p2;    // BCD accumulator
  logic [3:0]          iter;      // double-dabble iteration counter
  logic [PROD_W-1:0]   prod;
  logic [15:0]         adj;
  logic [15:0]         out_r [NCH];

`ifdef ADC_BCD_FRAME_SYNC_EN
  logic [15:0]         shadow [NCH];
`else
  logic                unused_frame_tick;
  assign unused_frame_tick = frame_tick;
`endif

  // Scale to millivolts (truncating) and saturate at the 4-digit limit.
  function automatic logic [COEF_W-1:0] sat_mv(input logic [PROD_W-1:0] p);
    logic [PROD_W-1:0] q;
    q = p >> 12;
    if (q > PROD_W'(MV_MAX)) begin
      return MV_MAX;
    end
    return q[COEF_W-1:0];
  endfunction

  // Double-dabble correction: add 3 to every BCD digit that is 5 or more so
  // that the following left shift carries correctly into the next digit.
  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = b[i*4 +: 4];
      end
    end
    return r;
  endfunction

  assign prod = PROD_W'(code_p0) * PROD_W'(SCALE_C);
  assign adj  = dabble_adj(bcd_p2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sample_ready <= 1'b1;
      updated      <= 1'b0;
      code_p0      <= '0;
      ch_p0        <= '0;
      mv_p1        <= '0;
      bcd_p2       <= '0;
      iter         <= '0;
      for (int i = 0; i < NCH; i++) begin
        out_r[i] <= '0;
`ifdef ADC_BCD_FRAME_SYNC_EN
        shadow[i] <= '0;
`endif
      end
    end else begin
      updated <= 1'b0;

`ifdef ADC_BCD_FRAME_SYNC_EN
      // Frame copy sees the shadows as they were before any same-edge write,
      // so a coincident conversion shows up on the following tick.
      if (frame_tick) begin
        for (int i = 0; i < NCH; i++) begin
          out_r[i] <= shadow[i];
        end
        updated <= 1'b1;
      end
`endif

      case (state)
        // ---- p0: accept and latch the sample ----
        IDLE: begin
          if (sample_valid && sample_ready) begin
            code_p0      <= sample;
            ch_p0        <= sample_ch;
            sample_ready <= 1'b0;
            state        <= MULT;
          end
        end

        // ---- p1: scale, saturate, prepare the converter ----
        MULT: begin
          mv_p1  <= sat_mv(prod);
          bcd_p2 <= '0;
          iter   <= '0;
          state  <= SHIFT;
        end

        // ---- p2: one double-dabble iteration per cycle ----
        SHIFT: begin
          bcd_p2 <= {adj[14:0], mv_p1[COEF_W-1]};
          mv_p1  <= {mv_p1[COEF_W-2:0], 1'b0};
          iter   <= iter + 4'd1;
          if (iter == LAST_IT) begin
            state <= WRITE;
          end
        end

        // ---- result commit ----
        WRITE: begin
          // Channels 13..15 are dropped without touching any output.
          if (ch_p0 < NCH_C) begin
`ifdef ADC_BCD_FRAME_SYNC_EN
            shadow[ch_p0] <= bcd_p2;
`else
            out_r[ch_p0]  <= bcd_p2;
            updated       <= 1'b1;
`endif
          end
          sample_ready <= 1'b1;
          state        <= IDLE;
        end

        default: begin
          sample_ready <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign out0  = out_r[0];
  assign out1  = out_r[1];
  assign out2  = out_r[2];
  assign out3  = out_r[3];
  assign out4  = out_r[4];
  assign out5  = out_r[5];
  assign out6  = out_r[6];
  assign out7  = out_r[7];
  assign out8  = out_r[8];
  assign out9  = out_r[9];
  assign out10 = out_r[10];
  assign out11 = out_r[11];
  assign out12 = out_r[12];

endmodule

// File: tb/tb_adc_bcd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_bcd_sequencer
//
// Directed bench for adc_bcd_sequencer in its default build. Three instances
// with SCALE = 3300, 16383 and 10000 share the same stimulus and run in
// lockstep. Expected output words are hand-computed constants for the single
// conversions and a divide-by-ten reference for the back-to-back sweep.
// -----------------------------------------------------------------------------
module tb_adc_bcd_sequencer;

  logic        clk;
  logic        rst;
  logic [11:0] sample;
  logic [3:0]  sample_ch;
  logic        sample_valid;
  logic        frame_tick;
  logic        ready_a, ready_b, ready_c;
  logic        upd_a, upd_b, upd_c;
  logic [15:0] oa [13];
  logic [15:0] ob [13];
  logic [15:0] oc [13];
  logic [15:0] ea [13];
  logic [15:0] eb [13];
  logic [15:0] ec [13];

  int n_asrt;
  int n_fail;
  int cyc;

  // values captured by send()
  logic        ready15, ready16, upd16;
  logic [15:0] pre_val;
  int          upd_cnt;

  adc_bcd_sequencer #(.SCALE(3300), .NCH(13)) dut_a (
    .clk(clk), .rst(rst), .sample(sample), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .sample_ready(ready_a), .frame_tick(frame_tick),
    .out0(oa[0]), .out1(oa[1]), .out2(oa[2]), .out3(oa[3]), .out4(oa[4]),
    .out5(oa[5]), .out6(oa[6]), .out7(oa[7]), .out8(oa[8]), .out9(oa[9]),
    .out10(oa[10]), .out11(oa[11]), .out12(oa[12]), .updated(upd_a)
  );

  adc_bcd_sequencer #(.SCALE(16383), .NCH(13)) dut_b (
    .clk(clk), .rst(rst), .sample(sample), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .sample_ready(ready_b), .frame_tick(frame_tick),
    .out0(ob[0]), .out1(ob[1]), .out2(ob[2]), .out3(ob[3]), .out4(ob[4]),
    .out5(ob[5]), .out6(ob[6]), .out7(ob[7]), .out8(ob[8]), .out9(ob[9]),
    .out10(ob[10]), .out11(ob[11]), .out12(ob[12]), .updated(upd_b)
  );

  adc_bcd_sequencer #(.SCALE(10000), .NCH(13)) dut_c (
    .clk(clk), .rst(rst), .sample(sample), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .sample_ready(ready_c), .frame_tick(frame_tick),
    .out0(oc[0]), .out1(oc[1]), .out2(oc[2]), .out3(oc[3]), .out4(oc[4]),
    .out5(oc[5]), .out6(oc[6]), .out7(oc[7]), .out8(oc[8]), .out9(oc[9]),
    .out10(oc[10]), .out11(oc[11]), .out12(oc[12]), .updated(upd_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // frame_tick has no effect in the default build; pulse it anyway
  initial begin
    frame_tick = 1'b0;
    forever begin
      repeat (7) @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("%s_a_out%0d", tag, i), {16'h0, oa[i]}, {16'h0, ea[i]});
      check($sformatf("%s_b_out%0d", tag, i), {16'h0, ob[i]}, {16'h0, eb[i]});
      check($sformatf("%s_c_out%0d", tag, i), {16'h0, oc[i]}, {16'h0, ec[i]});
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int code, input int scale);
    int mv;
    mv = (code * scale) / 4096;
    if (mv > 9999) mv = 9999;
    return {4'(mv / 1000), 4'((mv / 100) % 10), 4'((mv / 10) % 10), 4'(mv % 10)};
  endfunction

  // One conversion; accept edge is T. Records ready at T+15/T+16, updated at
  // T+16, the target word at T+15 and the number of updated pulses.
  task automatic send(input logic [11:0] code, input logic [3:0] ch, input bit noise);
    int g;
    g = 0;
    @(negedge clk);
    while (!ready_a && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("ready_before_accept", {31'h0, ready_a}, 32'h1);
    sample       = code;
    sample_ch    = ch;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = noise;
    if (noise) begin
      sample    = 12'hFFF;
      sample_ch = 4'd7;
    end
    upd_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 15) begin
        ready15      = ready_a;
        pre_val      = (ch < 4'd13) ? oa[ch] : 16'h0;
        sample_valid = 1'b0;
      end
      if (k == 16) begin
        ready16 = ready_a;
        upd16   = upd_a;
      end
      if (upd_a) upd_cnt++;
    end
  endtask

  initial begin
    int g, acc, prev;
    logic [11:0] c;
    n_asrt = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b1;
    sample = '0;
    sample_ch = '0;
    sample_valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      ea[i] = 16'h0; eb[i] = 16'h0; ec[i] = 16'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    #1;
    check("rst_ready", {31'h0, ready_a}, 32'h1);
    check("rst_updated", {31'h0, upd_a}, 32'h0);
    check_all("rst");

    // full scale on ch0
    send(12'd4095, 4'd0, 1'b0);
    check("fs_ready15", {31'h0, ready15}, 32'h0);
    check("fs_pre", {16'h0, pre_val}, 32'h0);
    check("fs_ready16", {31'h0, ready16}, 32'h1);
    check("fs_upd16", {31'h0, upd16}, 32'h1);
    check("fs_updcnt", upd_cnt, 1);
    ea[0] = 16'h3299; eb[0] = 16'h9999; ec[0] = 16'h9997;
    check_all("fs");

    // clamp case on ch3
    send(12'd4095, 4'd3, 1'b0);
    check("clamp_updcnt", upd_cnt, 1);
    ea[3] = 16'h3299; eb[3] = 16'h9999; ec[3] = 16'h9997;
    check_all("clamp");

    // mid scale on ch5 with valid/sample noise while busy
    send(12'd2048, 4'd5, 1'b1);
    check("mid_ready16", {31'h0, ready16}, 32'h1);
    check("mid_updcnt", upd_cnt, 1);
    ea[5] = 16'h1650; eb[5] = 16'h8191; ec[5] = 16'h5000;
    check_all("mid");

    // ch12 set then cleared by a zero code
    send(12'd4095, 4'd12, 1'b0);
    ea[12] = 16'h3299; eb[12] = 16'h9999; ec[12] = 16'h9997;
    check_all("ch12_fs");
    send(12'd0, 4'd12, 1'b0);
    check("zero_pre", {16'h0, pre_val}, 32'h3299);
    check("zero_updcnt", upd_cnt, 1);
    ea[12] = 16'h0000; eb[12] = 16'h0000; ec[12] = 16'h0000;
    check_all("zero");

    // out-of-range channel is dropped
    send(12'd1000, 4'd13, 1'b0);
    check("oor_ready15", {31'h0, ready15}, 32'h0);
    check("oor_ready16", {31'h0, ready16}, 32'h1);
    check("oor_updcnt", upd_cnt, 0);
    check_all("oor");

    // back-to-back with valid held high
    prev = 0;
    sample_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      c = 12'(i * 311 + 5);
      sample    = c;
      sample_ch = 4'(i);
      g = 0;
      while (!ready_a && g < 40) begin
        @(negedge clk);
        g++;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      if (i > 0) check($sformatf("b2b_gap%0d", i), acc - prev, 17);
      prev = acc;
      ea[i] = ref_bcd(int'(c), 3300);
      eb[i] = ref_bcd(int'(c), 16383);
      ec[i] = ref_bcd(int'(c), 10000);
    end
    sample_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check_all("b2b");

    // reset in the middle of a conversion
    @(negedge clk);
    sample       = 12'd4095;
    sample_ch    = 4'd1;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 13; i++) begin
      ea[i] = 16'h0; eb[i] = 16'h0; ec[i] = 16'h0;
    end
    check("midrst_ready", {31'h0, ready_a}, 32'h1);
    check("midrst_updated", {31'h0, upd_a}, 32'h0);
    check_all("midrst");
    @(negedge clk);
    rst = 1'b0;
    upd_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (upd_a) upd_cnt++;
    end
    check("midrst_updcnt", upd_cnt, 0);
    check("midrst_ready_after", {31'h0, ready_a}, 32'h1);
    check_all("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
